// File: rtl/force_release_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : force_release_ctrl
// Description : Round-robin arbitrated force/release override for e = a&b&c,
//               with a guaranteed release via a hold-time watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module force_release_ctrl #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic [N_REQ-1:0] force_req,
    input  logic [N_REQ-1:0] force_val,
    input  logic [N_REQ-1:0] release_req,
    output logic             e,
    output logic [N_REQ-1:0] grant,
    output logic             active,
    output logic             timeout_err,
    output logic [N_REQ-1:0] timeout_id,
    output logic             stray_release
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FORCED   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             latched_q, latched_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             active_q, active_d;
    logic             terr_q, terr_d;
    logic [N_REQ-1:0] tid_q, tid_d;
    logic             stray_q, stray_d;
    logic             e_q, e_d;

    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic             w_owner_rel;
    logic             w_hold_done;

    // Index arithmetic modulo N_REQ, valid for non-power-of-two N_REQ too.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return s[IDX_W-1:0];
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && force_req[wrap_idx(ptr_q, i)]) begin
                w_found = 1'b1;
                w_pick  = wrap_idx(ptr_q, i);
            end
        end
    end

    // grant_q is all-zero outside FORCED, so any release bit there is stray.
    assign w_owner_rel = |(release_req & grant_q);
    assign w_hold_done = (cnt_q == c_HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        latched_d = latched_q;
        grant_d   = grant_q;
        active_d  = active_q;
        terr_d    = terr_q;
        tid_d     = tid_q;
        stray_d   = |(release_req & ~grant_q);

        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    grant_d         = '0;
                    grant_d[w_pick] = 1'b1;
                    owner_d         = w_pick;
                    latched_d       = force_val[w_pick];
                    active_d        = 1'b1;
                    cnt_d           = '0;
                    state_d         = ST_FORCED;
                end
            end
            ST_FORCED: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (w_owner_rel || w_hold_done) begin
                    state_d  = ST_COOLDOWN;
                    grant_d  = '0;
                    active_d = 1'b0;
                    cnt_d    = '0;
                    ptr_d    = wrap_idx(owner_q, 1);
                    // An owner release on the last allowed cycle wins over the watchdog.
                    if (!w_owner_rel) begin
                        terr_d = 1'b1;
                        tid_d  = grant_q;
                    end
                end
            end
            ST_COOLDOWN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                active_d = 1'b0;
            end
        endcase

        e_d = active_d ? latched_d : (a & b & c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            latched_q <= 1'b0;
            grant_q   <= '0;
            active_q  <= 1'b0;
            terr_q    <= 1'b0;
            tid_q     <= '0;
            stray_q   <= 1'b0;
            e_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            latched_q <= latched_d;
            grant_q   <= grant_d;
            active_q  <= active_d;
            terr_q    <= terr_d;
            tid_q     <= tid_d;
            stray_q   <= stray_d;
            e_q       <= e_d;
        end
    end

    assign e             = e_q;
    assign grant         = grant_q;
    assign active        = active_q;
    assign timeout_err   = terr_q;
    assign timeout_id    = tid_q;
    assign stray_release = stray_q;

endmodule
`default_nettype wire

// File: tb/tb_force_release_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_force_release_ctrl
// Description : Directed scoreboard bench for force_release_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_force_release_ctrl;

    logic       clk;
    logic       rst;
    logic       a, b, c;
    logic [3:0] force_req, force_val, release_req;
    logic       e, active, timeout_err, stray_release;
    logic [3:0] grant, timeout_id;

    force_release_ctrl #(.N_REQ(4), .MAX_HOLD(16), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .a             (a),
        .b             (b),
        .c             (c),
        .force_req     (force_req),
        .force_val     (force_val),
        .release_req   (release_req),
        .e             (e),
        .grant         (grant),
        .active        (active),
        .timeout_err   (timeout_err),
        .timeout_id    (timeout_id),
        .stray_release (stray_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {e, grant[3:0], active, timeout_err, timeout_id[3:0], stray}
    typedef struct {
        int         step;
        logic [11:0] v;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_n   = 0;

    // Push the outputs expected after the next rising edge, then advance.
    task automatic cyc(input logic ee, input logic [3:0] gg, input logic aa,
                       input logic tt, input logic [3:0] ii, input logic ss);
        exp_t x;
        x.step = step_n;
        x.v    = {ee, gg, aa, tt, ii, ss};
        q.push_back(x);
        step_n++;
        @(negedge clk);
    endtask

    always begin
        exp_t x;
        logic [11:0] act;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            x   = q.pop_front();
            act = {e, grant, active, timeout_err, timeout_id, stray_release};
            n_checks++;
            if (act !== x.v) begin
                n_fail++;
                $display("FAIL step%0d outputs{e,grant,active,terr,tid,stray}: got %b_%b_%b_%b_%b_%b required %b_%b_%b_%b_%b_%b",
                         x.step, act[11], act[10:7], act[6], act[5], act[4:1], act[0],
                         x.v[11], x.v[10:7], x.v[6], x.v[5], x.v[4:1], x.v[0]);
            end
        end
    end

    initial begin
        rst = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0;
        force_req = '0; force_val = '0; release_req = '0;

        // Reset state
        cyc(0, 4'b0000, 0, 0, 4'b0000, 0);
        cyc(0, 4'b0000, 0, 0, 4'b0000, 0);

        // Plain AND path, one-cycle latency
        rst = 1'b0; a = 1; b = 1; c = 1;
        cyc(1, 4'b0000, 0, 0, 4'b0000, 0);
        cyc(1, 4'b0000, 0, 0, 4'b0000, 0);

        // Requester 1 forces 0, releases on the third FORCED cycle
        force_req = 4'b0010; force_val = 4'b0000;
        cyc(0, 4'b0010, 1, 0, 4'b0000, 0);
        force_req = 4'b0000;
        cyc(0, 4'b0010, 1, 0, 4'b0000, 0);
        cyc(0, 4'b0010, 1, 0, 4'b0000, 0);
        release_req = 4'b0010;
        cyc(1, 4'b0000, 0, 0, 4'b0000, 0);
        release_req = 4'b0000;
        cyc(1, 4'b0000, 0, 0, 4'b0000, 0);

        // Round robin between 1 and 3; pointer sits at 2 after the last release
        force_req = 4'b1010; force_val = 4'b1010; a = 0;
        cyc(1, 4'b1000, 1, 0, 4'b0000, 0);
        release_req = 4'b1000;
        cyc(0, 4'b0000, 0, 0, 4'b0000, 0);
        release_req = 4'b0000;
        cyc(0, 4'b0000, 0, 0, 4'b0000, 0);
        cyc(1, 4'b0010, 1, 0, 4'b0000, 0);
        release_req = 4'b0010;
        cyc(0, 4'b0000, 0, 0, 4'b0000, 0);
        release_req = 4'b0000;
        cyc(0, 4'b0000, 0, 0, 4'b0000, 0);
        cyc(1, 4'b1000, 1, 0, 4'b0000, 0);
        release_req = 4'b1000;
        cyc(0, 4'b0000, 0, 0, 4'b0000, 0);
        release_req = 4'b0000; force_req = 4'b0000;
        cyc(0, 4'b0000, 0, 0, 4'b0000, 0);

        // Requester 2 forces 1 and never releases; later requests/values ignored
        force_req = 4'b0100; force_val = 4'b0100; a = 1; b = 1; c = 0;
        cyc(1, 4'b0100, 1, 0, 4'b0000, 0);
        force_req = 4'b1111; force_val = 4'b0000;
        for (int i = 0; i < 15; i++) cyc(1, 4'b0100, 1, 0, 4'b0000, 0);
        cyc(0, 4'b0000, 0, 1, 4'b0100, 0);
        cyc(0, 4'b0000, 0, 1, 4'b0100, 0);

        // Requester 0 times out too; pointer wraps 3 -> 0
        force_req = 4'b0001; force_val = 4'b0000; a = 1; b = 1; c = 1;
        cyc(0, 4'b0001, 1, 1, 4'b0100, 0);
        force_req = 4'b0000;
        for (int i = 0; i < 15; i++) cyc(0, 4'b0001, 1, 1, 4'b0100, 0);
        cyc(1, 4'b0000, 0, 1, 4'b0001, 0);
        cyc(1, 4'b0000, 0, 1, 4'b0001, 0);

        // Reset in the middle of an override
        force_req = 4'b0010; force_val = 4'b0010; a = 0; b = 0; c = 0;
        cyc(1, 4'b0010, 1, 1, 4'b0001, 0);
        force_req = 4'b0000;
        cyc(1, 4'b0010, 1, 1, 4'b0001, 0);
        rst = 1'b1;
        cyc(0, 4'b0000, 0, 0, 4'b0000, 0);
        rst = 1'b0; a = 1; b = 1; c = 1;
        cyc(1, 4'b0000, 0, 0, 4'b0000, 0);

        // Pointer back at 0; stray release from 3; owner release on last hold cycle
        force_req = 4'b1111; force_val = 4'b0000;
        cyc(0, 4'b0001, 1, 0, 4'b0000, 0);
        force_req = 4'b0000; release_req = 4'b1000;
        cyc(0, 4'b0001, 1, 0, 4'b0000, 1);
        release_req = 4'b0000;
        for (int i = 0; i < 14; i++) cyc(0, 4'b0001, 1, 0, 4'b0000, 0);
        release_req = 4'b0001;
        cyc(1, 4'b0000, 0, 0, 4'b0000, 0);
        release_req = 4'b0100;
        cyc(1, 4'b0000, 0, 0, 4'b0000, 1);
        release_req = 4'b0000;
        cyc(1, 4'b0000, 0, 0, 4'b0000, 0);
        release_req = 4'b0001;
        cyc(1, 4'b0000, 0, 0, 4'b0000, 1);
        release_req = 4'b0000;
        cyc(1, 4'b0000, 0, 0, 4'b0000, 0);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
